// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered WIDTH-bit ALU with accumulator, stored carry, sticky overflow and valid/ready handshake
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             use_acc,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             ovf_sticky
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADDC = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic             r_carry_q;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_negative;
    logic             r_overflow;
    logic             r_sticky;

    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    // The output slot is free when empty or when it drains this cycle.
    assign in_ready  = (r_state == S_EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_FULL);

    assign w_op_a = use_acc ? r_acc : a;
    // The stored carry only feeds the adder for ADDC.
    assign w_sum  = {1'b0, w_op_a} + {1'b0, b}
                  + {{WIDTH{1'b0}}, (sel == OP_ADDC) && r_carry_q};
    // Extra top bit of the difference is the unsigned borrow.
    assign w_diff = {1'b0, w_op_a} - {1'b0, b};

    // Operation select: result, carry/borrow/shift-out and signed overflow.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (sel)
            OP_ADD, OP_ADDC: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_op_a[WIDTH-1] == b[WIDTH-1])
                       && (w_res[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (w_op_a[WIDTH-1] != b[WIDTH-1])
                       && (w_res[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            OP_AND: w_res = w_op_a & b;
            OP_OR:  w_res = w_op_a | b;
            OP_XOR: w_res = w_op_a ^ b;
            OP_SHL: begin
                w_res   = {w_op_a[WIDTH-2:0], 1'b0};
                w_carry = w_op_a[WIDTH-1];
            end
            OP_SHR: begin
                w_res   = {1'b0, w_op_a[WIDTH-1:1]};
                w_carry = w_op_a[0];
            end
        endcase
    end

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Output slot next state: fill on accept, drain when consumed without refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (out_ready && !w_accept) w_state_nxt = S_EMPTY;
        endcase
    end

    // Result, flags, accumulator and stored carry load together on accept only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
            r_acc      <= '0;
            r_carry_q  <= 1'b0;
        end else if (w_accept) begin
            r_result   <= w_res;
            r_carry    <= w_carry;
            r_zero     <= (w_res == '0);
            r_negative <= w_res[WIDTH-1];
            r_overflow <= w_ovf;
            r_acc      <= w_res;
            r_carry_q  <= w_carry;
        end
    end

    // Sticky overflow: a new overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)                      r_sticky <= 1'b0;
        else if (w_accept && w_ovf)   r_sticky <= 1'b1;
        else if (clr_sticky)          r_sticky <= 1'b0;
    end

    assign result     = r_result;
    assign carry      = r_carry;
    assign zero       = r_zero;
    assign negative   = r_negative;
    assign overflow   = r_overflow;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;

    localparam int W    = 8;
    localparam int MOD  = 256;
    localparam int HALF = 128;

    localparam int ADD  = 0;
    localparam int SUB  = 1;
    localparam int AND_ = 2;
    localparam int OR_  = 3;
    localparam int XOR_ = 4;
    localparam int ADDC = 5;
    localparam int SHL  = 6;
    localparam int SHR  = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         use_acc;
    logic         clr_sticky;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         ovf_sticky;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .use_acc    (use_acc),
        .clr_sticky (clr_sticky),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept as plain integers.
    int m_acc, m_cq, m_sticky, m_valid;
    int m_res, m_c, m_z, m_n, m_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_s(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    function automatic int out_of_range(input int s);
        return (s > HALF - 1 || s < -HALF) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cq = 0; m_sticky = 0; m_valid = 0;
        m_res = 0; m_c = 0; m_z = 0; m_n = 0; m_o = 0;
    endtask

    task automatic model_edge(input int iv, input int ia, input int ib, input int isel,
                              input int iua, input int iclr, input int iordy);
        int rdy, acc_ok, opa, full, res, c, o;
        rdy    = (m_valid == 0 || iordy != 0) ? 1 : 0;
        acc_ok = (iv != 0 && rdy != 0) ? 1 : 0;
        o      = 0;
        if (acc_ok != 0) begin
            opa = (iua != 0) ? m_acc : ia;
            res = 0; c = 0;
            case (isel)
                ADD, ADDC: begin
                    full = opa + ib + ((isel == ADDC) ? m_cq : 0);
                    res  = full % MOD;
                    c    = (full >= MOD) ? 1 : 0;
                    o    = out_of_range(to_s(opa) + to_s(ib) + ((isel == ADDC) ? m_cq : 0));
                end
                SUB: begin
                    res = (opa - ib + MOD) % MOD;
                    c   = (opa < ib) ? 1 : 0;
                    o   = out_of_range(to_s(opa) - to_s(ib));
                end
                AND_: res = opa & ib;
                OR_:  res = opa | ib;
                XOR_: res = opa ^ ib;
                SHL: begin
                    res = (opa * 2) % MOD;
                    c   = (opa >= HALF) ? 1 : 0;
                end
                default: begin
                    res = opa / 2;
                    c   = opa % 2;
                end
            endcase
            m_res = res; m_c = c; m_o = o;
            m_z   = (res == 0) ? 1 : 0;
            m_n   = (res >= HALF) ? 1 : 0;
            m_acc = res;
            m_cq  = c;
        end
        if (acc_ok != 0 && o != 0) m_sticky = 1;
        else if (iclr != 0)        m_sticky = 0;
        if (acc_ok != 0)     m_valid = 1;
        else if (iordy != 0) m_valid = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid),  m_valid);
        check({tag, ".result"},    32'(result),     m_res);
        check({tag, ".carry"},     32'(carry),      m_c);
        check({tag, ".zero"},      32'(zero),       m_z);
        check({tag, ".negative"},  32'(negative),   m_n);
        check({tag, ".overflow"},  32'(overflow),   m_o);
        check({tag, ".sticky"},    32'(ovf_sticky), m_sticky);
    endtask

    // One clock: drive, check in_ready, advance model and DUT, check outputs.
    task automatic cycle(input int iv, input int ia, input int ib, input int isel,
                         input int iua, input int iclr, input int iordy, input string tag);
        rst        = 1'b0;
        in_valid   = iv[0];
        a          = ia[W-1:0];
        b          = ib[W-1:0];
        sel        = isel[2:0];
        use_acc    = iua[0];
        clr_sticky = iclr[0];
        out_ready  = iordy[0];
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), (m_valid == 0 || iordy != 0) ? 1 : 0);
        model_edge(iv, ia, ib, isel, iua, iclr, iordy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int iv, input int iordy);
        rst        = 1'b1;
        in_valid   = iv[0];
        out_ready  = iordy[0];
        clr_sticky = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
        check("reset.in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0;
        use_acc = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(0, 0);

        cycle(1, 'h7F, 'h01, ADD, 0, 0, 1, "add_ovf");
        check("add_ovf.result_c", 32'(result), 'h80);
        check("add_ovf.ovf_c",    32'(overflow), 1);
        check("add_ovf.neg_c",    32'(negative), 1);
        check("add_ovf.sticky_c", 32'(ovf_sticky), 1);

        cycle(1, 'h00, 'h01, SUB, 0, 0, 1, "sub_borrow");
        check("sub_borrow.result_c", 32'(result), 'hFF);
        check("sub_borrow.carry_c",  32'(carry), 1);

        cycle(1, 'hFF, 'h01, ADD, 0, 0, 1, "add_wrap");
        check("add_wrap.zero_c",  32'(zero), 1);
        check("add_wrap.carry_c", 32'(carry), 1);

        cycle(1, 'h00, 'h00, ADDC, 0, 0, 1, "addc");
        check("addc.result_c", 32'(result), 'h01);
        check("addc.carry_c",  32'(carry), 0);

        cycle(1, 'h05, 'h03, ADD, 0, 0, 1, "acc_add");
        check("acc_add.result_c", 32'(result), 'h08);
        cycle(1, 'h00, 'h00, SHL, 1, 0, 1, "acc_shl");
        check("acc_shl.result_c", 32'(result), 'h10);
        cycle(1, 'h00, 'hFF, XOR_, 1, 0, 1, "acc_xor");
        check("acc_xor.result_c", 32'(result), 'hEF);

        cycle(0, 0, 0, ADD, 0, 0, 1, "drain");
        cycle(1, 'h11, 'h22, ADD, 0, 0, 0, "bp_first");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 'h40, 'h02, SUB, 0, 0, 0, "bp_hold");
            check("bp_hold.result_c", 32'(result), 'h33);
        end
        cycle(1, 'h40, 'h02, SUB, 0, 0, 1, "bp_release");
        check("bp_release.result_c", 32'(result), 'h3E);

        cycle(0, 0, 0, ADD, 0, 1, 1, "clr_only");
        cycle(1, 'h7F, 'h01, ADD, 0, 1, 1, "set_beats_clr");
        check("set_beats_clr.sticky_c", 32'(ovf_sticky), 1);
        cycle(0, 0, 0, ADD, 0, 1, 1, "clr_after");
        check("clr_after.sticky_c", 32'(ovf_sticky), 0);

        cycle(1, 'hFF, 'h01, ADD, 0, 0, 0, "pre_rst");
        do_reset(1, 0);
        check("rst_mid.out_valid_c", 32'(out_valid), 0);
        cycle(1, 'h55, 'h02, ADDC, 1, 0, 1, "post_rst_addc");
        check("post_rst_addc.result_c", 32'(result), 'h02);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            end else begin
                cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? 1 : 0,
                      ($urandom_range(0, 3) != 0) ? 1 : 0, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
